data_mem_arbiter: RTL and testbench
===================================

// Module: data_mem_arbiter
// PURPOSE
//   Shares the single data_mem instance between two requesters.
//   Port 0 is the CPU load/store path; port 1 is the debug/loader path.
//   A req/done handshake carries one word access per transaction, and round-robin arbitration picks the winner.
//   Sits between the requesters and data_mem (WE/A/WD/RD); addresses are word indices.
// PARAMETERS
//   DATA       32   data word width
//   ADDR       32   address width
//   MEM_DEPTH  256  words in data_mem; addr >= MEM_DEPTH is out of range
// PORTS
//   clk     in   1     clock; all state updates on rising edge
//   rstn    in   1     reset, synchronous, active-low
//   req0    in   1     port 0 request; held high until done0
//   we0     in   1     port 0 write (1) / read (0); stable while req0
//   addr0   in   ADDR  port 0 word address; stable while req0
//   wdata0  in   DATA  port 0 write data; stable while req0
//   done0   out  1     one-cycle pulse: port 0 transaction complete
//   rdata0  out  DATA  port 0 read data; valid with done0 for reads
//   err0    out  1     with done0: address out of range, no access done
//   req1, we1, addr1, wdata1, done1, rdata1, err1: same roles for port 1
//   mem_WE  out  1     to data_mem WE
//   mem_A   out  ADDR  to data_mem A
//   mem_WD  out  DATA  to data_mem WD
//   mem_RD  in   DATA  from data_mem RD (combinational read)
//   busy    out  1     high in ACCESS and RESP states
// BEHAVIOUR
//   FSM states: IDLE, ACCESS, RESP.
//   Reset (rstn=0 at posedge):
//     - state=IDLE, last=1 (port 0 wins the first tie).
//     - done*/err*=0, rdata*=0.
//     - mem_WE is forced 0 combinationally while rstn=0.
//   IDLE:
//     - No request: stay in IDLE.
//     - One request: that port wins.
//     - Both request: the port != last wins.
//     - On a win: latch sel, we, addr and wdata; last<=sel; go to ACCESS.
//   ACCESS (exactly 1 cycle):
//     - Drives mem_A=addr_l and mem_WD=wdata_l.
//     - mem_WE = we_l & in_range & rstn.
//     - The write commits at the edge that ends ACCESS.
//     - At that edge: rdata_sel <= in_range&~we_l ? mem_RD : 0; err_sel <= ~in_range.
//     - Then go to RESP.
//   RESP (exactly 1 cycle): done_sel=1 and err_sel is valid; next state is IDLE.
//     - done/err deassert on the next edge; rdata holds until that port's next done.
//   Latency: req sampled in IDLE at edge N -> done high in cycle N+2.
//   Max throughput: one transaction per 3 cycles.
//   Requester drops req in the done cycle. A req still high in IDLE after RESP starts a new transaction.
//   Idle mem outputs: mem_WE=0, mem_A=0, mem_WD=0.
//   in_range = (addr_l < MEM_DEPTH), compared at full ADDR width with no truncation.
//   Simultaneous req changes during ACCESS/RESP are ignored; sampling happens only in IDLE.
//   Reset mid-operation: abort to IDLE, no done pulse, no write at the reset edge.
// CONFIGURATION
//   ARB_FIXED_PRIO_EN:
//     - defined: fixed priority, port 0 always wins a tie; last is unused.
//     - undefined: round-robin as above.
//     - A lone requester is always granted in both modes.
// TESTING
//   1. Reset, then req0 write addr=5 wdata=15 -> mem_WE=1, mem_A=5 for 1 cycle; done0 two cycles after req0 sampled; err0=0.
//   2. req0 read addr=5 after test 1 -> done0 with rdata0=15; mem_WE stays 0.
//   3. req0 and req1 held high together, 4 transactions -> grant order 0,1,0,1.
//      With ARB_FIXED_PRIO_EN the order is 0,0,0,0 while req0 stays high.
//   4. req1 write addr=256 wdata=7 -> done1=1, err1=1, mem_WE never 1; a later read of addr 255 is unaffected.
//   5. rstn=0 during ACCESS of a write -> no done pulse, state IDLE, mem_WE=0; the next req is served normally.
//   6. Back-to-back: 20 random reqs (addr 0-255, data 0-100) on both ports -> every req gets exactly one done.
//      Each read returns the last written value (scoreboard model); busy never high in IDLE.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Two-port req/done arbiter in front of the single-ported data_mem (CPU port 0, debug port 1).
// Round-robin by default; define ARB_FIXED_PRIO_EN to make port 0 win every tie.
module data_mem_arbiter #(
  parameter int unsigned DATA      = 32,
  parameter int unsigned ADDR      = 32,
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req0,
  input  logic            we0,
  input  logic [ADDR-1:0] addr0,
  input  logic [DATA-1:0] wdata0,
  output logic            done0,
  output logic [DATA-1:0] rdata0,
  output logic            err0,
  input  logic            req1,
  input  logic            we1,
  input  logic [ADDR-1:0] addr1,
  input  logic [DATA-1:0] wdata1,
  output logic            done1,
  output logic [DATA-1:0] rdata1,
  output logic            err1,
  output logic            mem_WE,
  output logic [ADDR-1:0] mem_A,
  output logic [DATA-1:0] mem_WD,
  input  logic [DATA-1:0] mem_RD,
  output logic            busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            last_q, last_d;
  logic            sel_q, sel_d;
  logic            we_q, we_d;
  logic [ADDR-1:0] addr_q, addr_d;
  logic [DATA-1:0] wdata_q, wdata_d;
  logic            done0_q, done0_d;
  logic            done1_q, done1_d;
  logic            err0_q, err0_d;
  logic            err1_q, err1_d;
  logic [DATA-1:0] rdata0_q, rdata0_d;
  logic [DATA-1:0] rdata1_q, rdata1_d;

  logic            grant_valid_c;
  logic            grant_sel_c;
  logic            in_range_c;
  logic [DATA-1:0] rd_val_c;

  // Full-width compare so high address bits can never alias into range.
  assign in_range_c = (addr_q < ADDR'(MEM_DEPTH));
  assign rd_val_c   = (in_range_c && !we_q) ? mem_RD : '0;

  // Winner selection; only consumed in IDLE.
  assign grant_valid_c = req0 | req1;
  always_comb begin
    grant_sel_c = 1'b0;
    if (req0 && req1) begin
`ifdef ARB_FIXED_PRIO_EN
      grant_sel_c = 1'b0;
`else
      grant_sel_c = ~last_q;
`endif
    end else if (req1) begin
      grant_sel_c = 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      last_q   <= 1'b1;
      sel_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Next-state logic: one cycle each in ACCESS and RESP.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (grant_valid_c) state_d = S_ACCESS;
      S_ACCESS: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output and latch logic.
  always_comb begin
    last_d   = last_q;
    sel_d    = sel_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    err0_d   = 1'b0;
    err1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    mem_WE   = 1'b0;
    mem_A    = '0;
    mem_WD   = '0;
    busy     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (grant_valid_c) begin
          sel_d   = grant_sel_c;
          last_d  = grant_sel_c;
          we_d    = grant_sel_c ? we1 : we0;
          addr_d  = grant_sel_c ? addr1 : addr0;
          wdata_d = grant_sel_c ? wdata1 : wdata0;
        end
      end
      S_ACCESS: begin
        busy   = 1'b1;
        mem_A  = addr_q;
        mem_WD = wdata_q;
        // Gating with rstn keeps a reset edge from committing a write.
        mem_WE = we_q & in_range_c & rstn;
        if (sel_q) begin
          done1_d  = 1'b1;
          err1_d   = ~in_range_c;
          rdata1_d = rd_val_c;
        end else begin
          done0_d  = 1'b1;
          err0_d   = ~in_range_c;
          rdata0_d = rd_val_c;
        end
      end
      S_RESP: begin
        busy = 1'b1;
      end
      default: ;
    endcase
  end

  assign done0  = done0_q;
  assign done1  = done1_q;
  assign err0   = err0_q;
  assign err1   = err1_q;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed plus random bench for data_mem_arbiter with a transaction-level memory/arbitration model.
module tb_data_mem_arbiter;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        done0, err0, done1, err1;
  logic [31:0] rdata0, rdata1;
  logic        mem_WE, busy;
  logic [31:0] mem_A, mem_WD, mem_RD;

  logic [31:0] mem [256];
  logic        clear_mem;

  logic [31:0] ref_mem [256];
  txn_t        q0[$];
  txn_t        q1[$];
  int          grants[$];
  int          total = 0;
  int          bad = 0;
  int          we_cnt, done_cnt0, done_cnt1, last_lat;
  logic [31:0] we_addr;
  logic        last_err;

  always #5 clk = ~clk;

  data_mem_arbiter dut (
    .clk(clk), .rstn(rstn),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .done0(done0), .rdata0(rdata0), .err0(err0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .done1(done1), .rdata1(rdata1), .err1(err1),
    .mem_WE(mem_WE), .mem_A(mem_A), .mem_WD(mem_WD), .mem_RD(mem_RD),
    .busy(busy)
  );

  // data_mem stand-in: combinational read, write on the rising edge.
  assign mem_RD = (mem_A < 32'd256) ? mem[mem_A[7:0]] : 32'hDEAD_BEEF;
  always @(posedge clk) begin
    if (clear_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (mem_WE) begin
      mem[mem_A[7:0]] <= mem_WD;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic txn_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    txn_t t;
    t.we = we;
    t.addr = addr;
    t.wdata = wdata;
    return t;
  endfunction

  task automatic finish_txn(input int p, input txn_t t, input logic [31:0] rd, input logic er,
                            input int lat);
    logic exp_err;
    exp_err = (t.addr >= 32'd256);
    chk($sformatf("err_p%0d_a%0h", p, t.addr), 32'(er), 32'(exp_err));
    if (!exp_err && !t.we) chk($sformatf("rdata_p%0d_a%0h", p, t.addr), rd, ref_mem[t.addr[7:0]]);
    else chk($sformatf("rdata_zero_p%0d", p), rd, 32'd0);
    if (!exp_err && t.we) ref_mem[t.addr[7:0]] = t.wdata;
    chk("busy_in_resp", 32'(busy), 32'd1);
    grants.push_back(p);
    last_lat = lat;
    last_err = er;
    if (p == 0) done_cnt0++; else done_cnt1++;
  endtask

  // Drives both requesters from their queues until every queued transaction is done.
  task automatic run_engine(input int limit);
    int   cyc;
    int   t0;
    int   t1;
    txn_t t;
    cyc = 0; t0 = 0; t1 = 0;
    we_cnt = 0;
    while ((q0.size() > 0 || q1.size() > 0 || req0 || req1) && cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (mem_WE) begin we_cnt++; we_addr = mem_A; end
      chk("done_exclusive", 32'(done0 & done1), 32'd0);
      if (!busy) begin
        chk("idle_mem_we", 32'(mem_WE), 32'd0);
        chk("idle_mem_a", mem_A, 32'd0);
      end
      if (done0) begin
        if (req0) begin t = q0.pop_front(); finish_txn(0, t, rdata0, err0, cyc - t0); end
        else chk("spurious_done0", 32'(done0), 32'd0);
        req0 = 1'b0;
      end else if (!req0 && q0.size() > 0) begin
        t = q0[0]; req0 = 1'b1; we0 = t.we; addr0 = t.addr; wdata0 = t.wdata; t0 = cyc;
      end
      if (done1) begin
        if (req1) begin t = q1.pop_front(); finish_txn(1, t, rdata1, err1, cyc - t1); end
        else chk("spurious_done1", 32'(done1), 32'd0);
        req1 = 1'b0;
      end else if (!req1 && q1.size() > 0) begin
        t = q1[0]; req1 = 1'b1; we1 = t.we; addr1 = t.addr; wdata1 = t.wdata; t1 = cyc;
      end
    end
    chk("engine_pending", 32'(q0.size() + q1.size()) + 32'(req0) + 32'(req1), 32'd0);
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0; req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mem_we", 32'(mem_WE), 32'd0);
    chk("rst_done", {30'd0, done1, done0}, 32'd0);
    chk("rst_err", {30'd0, err1, err0}, 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_rdata1", rdata1, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_mem_a", mem_A, 32'd0);
    chk("rst_mem_wd", mem_WD, 32'd0);
  endtask

  initial begin
    logic [31:0] exp_p;
    logic        mlast;
    int          n0;
    int          n1;
    txn_t        t;
    rstn = 1'b0; req0 = 1'b0; req1 = 1'b0;
    we0 = 1'b0; we1 = 1'b0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    clear_mem = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    do_reset();
    clear_mem = 1'b0;

    // 1: single write
    q0.push_back(mk(1'b1, 32'd5, 32'd15));
    run_engine(50);
    chk("t1_we_cycles", 32'(we_cnt), 32'd1);
    chk("t1_we_addr", we_addr, 32'd5);
    chk("t1_latency", 32'(last_lat), 32'd2);
    chk("t1_err", 32'(last_err), 32'd0);
    @(negedge clk);
    chk("t1_done_pulse", 32'(done0), 32'd0);
    chk("t1_busy_idle", 32'(busy), 32'd0);

    // 2: read back
    q0.push_back(mk(1'b0, 32'd5, 32'd0));
    run_engine(50);
    chk("t2_we_cycles", 32'(we_cnt), 32'd0);
    chk("t2_rdata", rdata0, 32'd15);

    // 4: out-of-range write on port 1
    q1.push_back(mk(1'b1, 32'd255, 32'd42));
    run_engine(50);
    q1.push_back(mk(1'b1, 32'd256, 32'd7));
    run_engine(50);
    chk("t4_we_cycles", 32'(we_cnt), 32'd0);
    chk("t4_err1", 32'(last_err), 32'd1);
    chk("t4_rdata1", rdata1, 32'd0);
    q0.push_back(mk(1'b0, 32'd255, 32'd0));
    run_engine(50);
    chk("t4_rd255", rdata0, 32'd42);

    // 5: reset during ACCESS of a write
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd9; wdata0 = 32'd77;
    @(negedge clk);
    chk("t5_access_we", 32'(mem_WE), 32'd1);
    rstn = 1'b0;
    @(negedge clk);
    chk("t5_done", 32'(done0), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_mem_we", 32'(mem_WE), 32'd0);
    req0 = 1'b0; rstn = 1'b1;
    @(negedge clk);
    chk("t5_done_after", 32'(done0), 32'd0);
    chk("t5_busy_after", 32'(busy), 32'd0);
    q0.push_back(mk(1'b0, 32'd9, 32'd0));
    run_engine(50);
    chk("t5_rd9", rdata0, ref_mem[9]);
    chk("t5_latency", 32'(last_lat), 32'd2);

    // 3: both ports hold requests
    do_reset();
    grants.delete();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(1'b1, 32'(20 + i), 32'(100 + i)));
      q1.push_back(mk(1'b0, 32'(20 + i), 32'd0));
    end
    run_engine(200);
    chk("t3_grant_count", 32'(grants.size()), 32'd8);
    mlast = 1'b1;
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_FIXED_PRIO_EN
      exp_p = 32'd0;
`else
      exp_p = mlast ? 32'd0 : 32'd1;
`endif
      mlast = exp_p[0];
      if (i < grants.size()) chk($sformatf("t3_grant%0d", i), 32'(grants[i]), exp_p);
    end

    // 6: random back-to-back traffic
    done_cnt0 = 0; done_cnt1 = 0; n0 = 0; n1 = 0;
    for (int i = 0; i < 20; i++) begin
      t = mk(1'($urandom_range(0, 1)),
             ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 7)) : 32'($urandom_range(0, 255)),
             32'($urandom_range(0, 100)));
      if ($urandom_range(0, 1) == 0) begin q0.push_back(t); n0++; end
      else begin q1.push_back(t); n1++; end
    end
    run_engine(2000);
    chk("t6_done0_count", 32'(done_cnt0), 32'(n0));
    chk("t6_done1_count", 32'(done_cnt1), 32'(n1));
    @(negedge clk);
    chk("t6_busy_end", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
